// File: rtl/jam_cost_scheduler.sv
// jam_cost_scheduler
//   Lets NREQ permutation-evaluation engines share one Cost-table read port.
//   A granted requester's 8-slot job-to-worker permutation is latched. The
//   block then reads Cost[W][J] for W = 0..7 and returns the 10-bit total
//   with a one-cycle ack/done pulse. Requesters are served round-robin.
//
//   state | meaning
//   IDLE  | waiting for req; grants round-robin starting at rr_ptr
//   ISSUE | presents W=beat, J=slot[beat] for beats 0..7
//   DRAIN | collects the Cost for W=7
//   RESP  | done/ack pulse, advances rr_ptr past the served requester
//
// Ports
//   CLK, RST            clock (rising edge), async active-high reset
//   req[NREQ]           per-requester level request
//   perm[24*NREQ]       requester i slot k = perm[24i+3k +: 3] (J for W=k)
//   ack[NREQ]           one-cycle pulse to the served requester
//   sum_out, done_id    result and requester index; held until next RESP
//   done, perm_err      completion pulse; duplicate-J flag for that job
//   busy                high from the cycle after grant through RESP
//   W, J, Cost          Cost memory port; Cost answers last cycle's W/J

module jam_cost_scheduler #(
  parameter int NREQ   = 2,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req,
  input  logic [24*NREQ-1:0] perm,
  output logic [NREQ-1:0]   ack,
  output logic [9:0]        sum_out,
  output logic              done,
  output logic [1:0]        done_id,
  output logic              perm_err,
  output logic              busy,
  output logic [2:0]        W,
  output logic [2:0]        J,
  input  logic [6:0]        Cost
);

  generate
    if (NREQ < 2 || NREQ > 4 || RD_LAT != 1) begin : g_param_check
      $error("jam_cost_scheduler: NREQ must be 2..4 and RD_LAT must be 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [1:0]       id_q;
  logic [2:0]       beat;
  logic [9:0]       acc;
  logic [7:0][2:0]  perm_q;

  logic             found;
  logic [1:0]       win_id;
  logic [23:0]      win_perm;
  logic             dup;
  logic [9:0]       acc_nxt;

  assign acc_nxt = acc + {3'b000, Cost};

  // Round-robin pick: first pass covers rr_ptr..NREQ-1, second pass wraps
  // to 0..rr_ptr-1 (anything it finds is below rr_ptr).
  always_comb begin
    found    = 1'b0;
    win_id   = 2'd0;
    win_perm = 24'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (2'(i) >= rr_ptr)) begin
        found    = 1'b1;
        win_id   = 2'(i);
        win_perm = perm[24*i +: 24];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        win_id   = 2'(i);
        win_perm = perm[24*i +: 24];
      end
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int a = 0; a < 7; a++) begin
      for (int b = a + 1; b < 8; b++) begin
        if (perm_q[a] == perm_q[b]) dup = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      id_q     <= 2'd0;
      beat     <= 3'd0;
      acc      <= 10'd0;
      perm_q   <= '0;
      ack      <= '0;
      sum_out  <= 10'd0;
      done     <= 1'b0;
      done_id  <= 2'd0;
      perm_err <= 1'b0;
      busy     <= 1'b0;
      W        <= 3'd0;
      J        <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            perm_q <= win_perm;
            id_q   <= win_id;
            acc    <= 10'd0;
            beat   <= 3'd0;
            busy   <= 1'b1;
            W      <= 3'd0;
            J      <= win_perm[2:0];
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // Beat 0's Cost belongs to whatever was addressed before the grant.
          if (beat != 3'd0) acc <= acc_nxt;
          if (beat == 3'd7) begin
            state <= DRAIN;
          end else begin
            beat <= beat + 3'd1;
            W    <= beat + 3'd1;
            J    <= perm_q[beat + 3'd1];
          end
        end
        DRAIN: begin
          // Result registers load here so they are visible during RESP.
          acc      <= acc_nxt;
          sum_out  <= acc_nxt;
          done     <= 1'b1;
          done_id  <= id_q;
          perm_err <= dup;
          for (int i = 0; i < NREQ; i++) ack[i] <= (2'(i) == id_q);
          state    <= RESP;
        end
        RESP: begin
          done   <= 1'b0;
          ack    <= '0;
          busy   <= 1'b0;
          rr_ptr <= (id_q == 2'(NREQ - 1)) ? 2'd0 : id_q + 2'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_scheduler.sv
// tb_jam_cost_scheduler
//   Directed bench for jam_cost_scheduler (NREQ=2). Cost memory model is a
//   one-cycle registered lookup: Cost = W*J, or a constant 127 when
//   cost_fix is set.

module tb_jam_cost_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [47:0] perm = 48'd0;
  logic [1:0]  ack;
  logic [9:0]  sum_out;
  logic        done;
  logic [1:0]  done_id;
  logic        perm_err;
  logic        busy;
  logic [2:0]  W;
  logic [2:0]  J;
  logic [6:0]  Cost = 7'd0;
  logic        cost_fix = 1'b0;

  int checks = 0;
  int errors = 0;

  jam_cost_scheduler #(.NREQ(2), .RD_LAT(1)) dut (
    .CLK(CLK), .RST(RST), .req(req), .perm(perm), .ack(ack),
    .sum_out(sum_out), .done(done), .done_id(done_id), .perm_err(perm_err),
    .busy(busy), .W(W), .J(J), .Cost(Cost)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    Cost <= cost_fix ? 7'd127 : 7'({4'b0000, W} * {4'b0000, J});

  function automatic logic [23:0] pk(input logic [2:0] a0, a1, a2, a3,
                                     a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Ticks until done is seen; n = ticks taken, or -1 if the bound expires.
  task automatic wait_done(output int n);
    n = 0;
    while (1) begin
      tick();
      n++;
      if (done) break;
      if (n >= 40) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    checks++;
    if ({ack, sum_out, done, done_id, perm_err, busy, W, J} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {ack, sum_out, done, done_id, perm_err, busy, W, J});
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    int n;
    perm[23:0] = pk(0, 1, 2, 3, 4, 5, 6, 7);
    req = 2'b01;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ident_busy got %b want 1", busy); end
    wait_done(n);
    checks++;
    if (n + 1 != 10) begin errors++; $display("FAIL ident_latency got %0d want 10", n + 1); end
    checks++;
    if (ack !== 2'b01) begin errors++; $display("FAIL ident_ack got %b want 01", ack); end
    checks++;
    if (sum_out !== 10'd140) begin errors++; $display("FAIL ident_sum got %0d want 140", sum_out); end
    checks++;
    if (perm_err !== 1'b0) begin errors++; $display("FAIL ident_perm_err got %b want 0", perm_err); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ident_busy_resp got %b want 1", busy); end
    req = 2'b00;
    tick();
    checks++;
    if ({done, ack, busy} !== 4'b0000) begin
      errors++; $display("FAIL ident_after_pulse got %b want 0000", {done, ack, busy});
    end
    checks++;
    if (sum_out !== 10'd140 || W !== 3'd7 || J !== 3'd7) begin
      errors++; $display("FAIL ident_hold got sum=%0d W=%0d J=%0d want 140 7 7", sum_out, W, J);
    end
  endtask

  task automatic test_reverse();
    int n;
    perm[47:24] = pk(7, 6, 5, 4, 3, 2, 1, 0);
    req = 2'b10;
    tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (W !== 3'(k) || J !== 3'(7 - k)) begin
        errors++; $display("FAIL rev_addr beat %0d got W=%0d J=%0d want %0d %0d", k, W, J, k, 7 - k);
      end
      if (k < 7) tick();
    end
    wait_done(n);
    checks++;
    if (n != 2) begin errors++; $display("FAIL rev_latency got %0d want 2", n); end
    checks++;
    if (sum_out !== 10'd56 || done_id !== 2'd1 || ack !== 2'b10) begin
      errors++; $display("FAIL rev_result got sum=%0d id=%0d ack=%b want 56 1 10", sum_out, done_id, ack);
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    cost_fix = 1'b1;
    perm = {pk(0, 1, 2, 3, 4, 5, 6, 7), pk(0, 1, 2, 3, 4, 5, 6, 7)};
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_done(n);
      if (j == 3) req = 2'b00;
      checks++;
      if (n != ((j == 0) ? 10 : 11)) begin
        errors++; $display("FAIL b2b_spacing job %0d got %0d want %0d", j, n, (j == 0) ? 10 : 11);
      end
      checks++;
      if (ack !== ((j % 2 == 0) ? 2'b01 : 2'b10) || done_id !== 2'(j % 2)) begin
        errors++; $display("FAIL b2b_order job %0d got ack=%b id=%0d want id %0d", j, ack, done_id, j % 2);
      end
      checks++;
      if (sum_out !== 10'd1016) begin errors++; $display("FAIL b2b_sum job %0d got %0d want 1016", j, sum_out); end
    end
    tick();
    cost_fix = 1'b0;
  endtask

  task automatic test_perm_err();
    int n;
    perm[23:0] = pk(0, 1, 3, 2, 4, 2, 6, 7);
    req = 2'b01;
    wait_done(n);
    req = 2'b00;
    checks++;
    if (n != 10) begin errors++; $display("FAIL perr_latency got %0d want 10", n); end
    checks++;
    if (perm_err !== 1'b1) begin errors++; $display("FAIL perr_flag got %b want 1", perm_err); end
    checks++;
    if (sum_out !== 10'd124 || done_id !== 2'd0) begin
      errors++; $display("FAIL perr_sum got sum=%0d id=%0d want 124 0", sum_out, done_id);
    end
    tick();
    checks++;
    if (perm_err !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL perr_hold got perm_err=%b done=%b want 1 0", perm_err, done);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic saw_done;
    perm = {pk(0, 1, 2, 3, 4, 5, 6, 7), pk(0, 1, 2, 3, 4, 5, 6, 7)};
    req = 2'b10;
    tick();
    repeat (4) tick();
    checks++;
    if (W !== 3'd4) begin errors++; $display("FAIL mid_beat got W=%0d want 4", W); end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({ack, sum_out, done, done_id, perm_err, busy, W, J} !== 23'd0) begin
      errors++; $display("FAIL mid_async_clear got %h want 0",
                         {ack, sum_out, done, done_id, perm_err, busy, W, J});
    end
    req = 2'b00;
    saw_done = 1'b0;
    repeat (3) begin
      tick();
      if (done || ack != 2'b00) saw_done = 1'b1;
    end
    RST = 1'b0;
    repeat (12) begin
      tick();
      if (done || ack != 2'b00) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL mid_no_ack got %b want 0", saw_done); end
    req = 2'b11;
    wait_done(n);
    req = 2'b00;
    checks++;
    if (n != 10 || done_id !== 2'd0 || sum_out !== 10'd140) begin
      errors++; $display("FAIL mid_restart got n=%0d id=%0d sum=%0d want 10 0 140", n, done_id, sum_out);
    end
    tick();
  endtask

  task automatic test_drop_change();
    int n;
    perm[47:24] = pk(7, 6, 5, 4, 3, 2, 1, 0);
    req = 2'b10;
    tick();
    req = 2'b00;
    perm[47:24] = pk(0, 1, 2, 3, 4, 5, 6, 7);
    wait_done(n);
    checks++;
    if (n != 9) begin errors++; $display("FAIL drop_latency got %0d want 9", n); end
    checks++;
    if (sum_out !== 10'd56 || ack !== 2'b10 || done_id !== 2'd1) begin
      errors++; $display("FAIL drop_result got sum=%0d ack=%b id=%0d want 56 10 1", sum_out, ack, done_id);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_reverse();
    test_back_to_back();
    test_perm_err();
    test_reset_mid();
    test_drop_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jam_cost_scheduler.md
Name: jam_cost_scheduler

Overview:
- Shares the single Cost-table read port (W/J address out, Cost back) among NREQ permutation-evaluation requesters.
- Each requester submits one full 8-entry job-to-worker permutation; the block arbitrates round-robin and issues the 8 row reads.
- It accumulates the 8 costs and returns the total with a one-cycle ack.
- It sits between the Cost memory and the evaluation engines, so several engines can search the permutation space against one cost table.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- RD_LAT, 1, Cost memory read latency in cycles; only 1 is supported, the parameter is documentation-only.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester job request, level
- perm  in  24*NREQ  packed permutations; requester i slot k = perm[24i+3k+2 : 24i+3k] = J for W=k
- ack  out  NREQ  one-cycle pulse to the winning requester when its result is valid
- sum_out  out  10  total cost of the completed job; valid while done=1
- done  out  1  one-cycle pulse, same cycle as ack
- done_id  out  2  index of the requester whose job completed; valid while done=1
- perm_err  out  1  high with done if the latched permutation contains a duplicate J
- busy  out  1  high from the cycle after grant until the RESP cycle inclusive
- W  out  3  Cost memory row (worker) address
- J  out  3  Cost memory column (job) address
- Cost  in  7  memory read data; corresponds to the W/J presented in the previous cycle

Behaviour:
- Reset: RST is asynchronous and active-high, CLK is the clock. On reset, state=IDLE, rr_ptr=0, beat=0, acc=0. All outputs are 0: W, J, ack, sum_out, done, done_id, perm_err, busy. All outputs are registered.
- IDLE:
  - If req is nonzero, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch the winner's 24-bit perm and its id, clear acc and beat, go to ISSUE.
  - req is sampled only in IDLE.
- ISSUE (8 cycles, beat 0..7):
  - W=beat, J=latched slot[beat].
  - If beat>0, acc += Cost (zero-extended to 10 bits).
  - After beat 7, go to DRAIN.
- DRAIN (1 cycle): acc += Cost for W=7, go to RESP.
- RESP (1 cycle):
  - done=1, ack[id]=1, sum_out=acc, done_id=id, perm_err computed from the latched perm.
  - rr_ptr = (id+1) mod NREQ; go to IDLE.
- Timing: req sampled in IDLE at cycle 0 → W=0 at cycle 1 → W=7 at cycle 8 → DRAIN at cycle 9 → ack at cycle 10. Throughput is one job per 11 cycles.
- Arithmetic: max sum is 8*127 = 1016, so 10 bits never overflow. No saturation logic.
- sum_out, done_id and perm_err hold their values after done drops, until the next RESP.
- W and J hold their last values outside ISSUE.
- Handshake:
  - A requester holds req=1 and perm stable until it sees ack.
  - It must drop req on the edge ending the ack cycle unless it intends a new job.
  - Deassertion of req after grant is ignored; the job completes with the latched perm.
  - perm changes after grant have no effect.
- Simultaneous requests: only one is granted per IDLE visit. Losers keep waiting; there are no starvation gaps, since rr_ptr guarantees service within NREQ jobs.
- perm_err does not abort the job; all 8 reads are still performed and the sum is still reported.
- Reset mid-job returns to the reset state immediately. No ack is issued for the aborted job.

Test Plan:
- Memory model Cost=W*J; requester 0 sends identity perm (J=W) → ack[0] exactly 10 cycles after the IDLE sample, sum_out=140, perm_err=0.
- Same model; requester 1 sends reversed perm (J=7-W) → sum_out=56, done_id=1; W steps 0..7 and J steps 7..0 on consecutive cycles.
- Cost fixed at 127, NREQ=2, both req high continuously with identity perms → acks alternate 0,1,0,1, each sum_out=1016, ack spacing 11 cycles.
- Requester 0 perm with slot3=slot5=2 → perm_err=1 with done; sum equals the model value for the given J sequence.
- Assert RST during ISSUE beat 4 → all outputs 0 asynchronously, no ack. After release, a new request completes normally with rr_ptr=0 priority.
- Requester drops req and changes perm during ISSUE → the result still matches the originally latched perm, and ack is still issued.
